// File: rtl/bsg_hold_time_test_bist_ctrl.sv
// BIST sequencer for the hold-time test 1r1w memory: write a pattern, read it back, compare.
// Define BSG_HOLD_TIME_TEST_BIST_INVERT_PASS_EN to add a second write/read pass with the inverted pattern.
module bsg_hold_time_test_bist_ctrl #(
  parameter  int width_p       = 34,
  parameter  int els_p         = 64,
  localparam int addr_width_lp = $clog2(els_p),
  localparam int cnt_width_lp  = $clog2(els_p+1)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic [1:0]               pattern_sel_i,
  output logic                     w_v_o,
  output logic [addr_width_lp-1:0] w_addr_o,
  output logic [width_p-1:0]       w_data_o,
  output logic                     r_v_o,
  output logic [addr_width_lp-1:0] r_addr_o,
  input  logic [width_p-1:0]       r_data_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic [cnt_width_lp-1:0]  err_count_o,
  output logic [addr_width_lp-1:0] first_err_addr_o
);

  // state       | meaning
  // e_idle      | waiting for start_i after reset
  // e_write     | writing pattern to addresses 0..els_p-1
  // e_read      | reading addresses 0..els_p-1
  // e_write_inv | writing inverted pattern (invert-pass build only)
  // e_read_inv  | reading inverted pattern back (invert-pass build only)
  // e_drain     | last read compare completes
  // e_done      | results valid and held until start_i or reset
`ifdef BSG_HOLD_TIME_TEST_BIST_INVERT_PASS_EN
  typedef enum logic [2:0] {
    e_idle, e_write, e_read, e_write_inv, e_read_inv, e_drain, e_done
  } state_e;
`else
  typedef enum logic [2:0] {
    e_idle, e_write, e_read, e_drain, e_done
  } state_e;
`endif

  localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

  function automatic logic [width_p-1:0] pattern_f(input logic [1:0]               sel,
                                                   input logic [addr_width_lp-1:0] a);
    logic [width_p-1:0] p;
    p = '0;
    for (int i = 0; i < width_p; i++) begin
      case (sel)
        2'd0:    p[i] = 1'b0;
        2'd1:    p[i] = 1'b1;
        2'd2:    p[i] = (i % 2 == 1) ^ a[0];
        default: p[i] = a[i % addr_width_lp];
      endcase
    end
    return p;
  endfunction

  state_e                   state_q, state_n;
  logic [addr_width_lp-1:0] addr_q, addr_n;
  logic [1:0]               pat_q;
  logic                     rd_v_q;
  logic [addr_width_lp-1:0] rd_addr_q;
  logic                     rd_inv_q;
  logic [cnt_width_lp-1:0]  err_q;
  logic [addr_width_lp-1:0] first_q;

  logic                     start_ok;
  logic                     w_v, r_v, inv_phase;
  logic [width_p-1:0]       exp_data;
  logic                     mismatch;

  always_comb begin
    state_n   = state_q;
    addr_n    = addr_q;
    start_ok  = 1'b0;
    w_v       = 1'b0;
    r_v       = 1'b0;
    inv_phase = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state_q)
      e_idle, e_done: begin
        done_o = (state_q == e_done) && !start_i;
        if (start_i) begin
          start_ok = 1'b1;
          addr_n   = '0;
          state_n  = e_write;
        end
      end
      e_write: begin
        w_v    = 1'b1;
        busy_o = 1'b1;
        addr_n = addr_q + addr_width_lp'(1);
        if (addr_q == last_addr_lp) begin
          addr_n  = '0;
          state_n = e_read;
        end
      end
      e_read: begin
        r_v    = 1'b1;
        busy_o = 1'b1;
        addr_n = addr_q + addr_width_lp'(1);
        if (addr_q == last_addr_lp) begin
          addr_n = '0;
`ifdef BSG_HOLD_TIME_TEST_BIST_INVERT_PASS_EN
          state_n = e_write_inv;
`else
          state_n = e_drain;
`endif
        end
      end
`ifdef BSG_HOLD_TIME_TEST_BIST_INVERT_PASS_EN
      e_write_inv: begin
        w_v       = 1'b1;
        inv_phase = 1'b1;
        busy_o    = 1'b1;
        addr_n    = addr_q + addr_width_lp'(1);
        if (addr_q == last_addr_lp) begin
          addr_n  = '0;
          state_n = e_read_inv;
        end
      end
      e_read_inv: begin
        r_v       = 1'b1;
        inv_phase = 1'b1;
        busy_o    = 1'b1;
        addr_n    = addr_q + addr_width_lp'(1);
        if (addr_q == last_addr_lp) begin
          addr_n  = '0;
          state_n = e_drain;
        end
      end
`endif
      e_drain: begin
        busy_o  = 1'b1;
        state_n = e_done;
      end
      default: state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= e_idle;
      addr_q    <= '0;
      pat_q     <= '0;
      rd_v_q    <= 1'b0;
      rd_addr_q <= '0;
      rd_inv_q  <= 1'b0;
      err_q     <= '0;
      first_q   <= '0;
    end else begin
      state_q   <= state_n;
      addr_q    <= addr_n;
      rd_v_q    <= r_v;
      rd_addr_q <= r_v ? addr_q : '0;
      rd_inv_q  <= r_v & inv_phase;
      if (start_ok) begin
        pat_q   <= pattern_sel_i;
        err_q   <= '0;
        first_q <= '0;
      end else if (mismatch) begin
        err_q <= err_q + cnt_width_lp'(1);
        if (err_q == '0) first_q <= rd_addr_q;
      end
    end
  end

  // Expected value follows the registered read address, so the final read of
  // one phase is still checked against its own phase polarity.
  assign exp_data = pattern_f(pat_q, rd_addr_q) ^ {width_p{rd_inv_q}};
  assign mismatch = rd_v_q && (r_data_i != exp_data);

  assign w_v_o            = w_v;
  assign w_addr_o         = w_v ? addr_q : '0;
  assign w_data_o         = w_v ? (pattern_f(pat_q, addr_q) ^ {width_p{inv_phase}}) : '0;
  assign r_v_o            = r_v;
  assign r_addr_o         = r_v ? addr_q : '0;
  assign err_count_o      = err_q;
  assign first_err_addr_o = first_q;
  assign pass_o           = done_o && (err_q == '0);

endmodule

// File: tb/tb_bsg_hold_time_test_bist_ctrl.sv
// Bench for bsg_hold_time_test_bist_ctrl: memory model with fault injection and an array-based reference.
module tb_bsg_hold_time_test_bist_ctrl;
  localparam int W  = 34;
  localparam int E  = 64;
  localparam int AW = 6;
  localparam int CW = 7;
`ifdef BSG_HOLD_TIME_TEST_BIST_INVERT_PASS_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int LAT = 2*PASSES*E + 2;

  logic          clk = 0, reset_i = 1, start_i = 0;
  logic [1:0]    pattern_sel_i = 0;
  logic          w_v_o, r_v_o, busy_o, done_o, pass_o;
  logic [AW-1:0] w_addr_o, r_addr_o, first_err_addr_o;
  logic [W-1:0]  w_data_o;
  logic [W-1:0]  r_data_i = '0;
  logic [CW-1:0] err_count_o;

  bsg_hold_time_test_bist_ctrl dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .pattern_sel_i(pattern_sel_i),
    .w_v_o(w_v_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o),
    .r_v_o(r_v_o), .r_addr_o(r_addr_o), .r_data_i(r_data_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .err_count_o(err_count_o), .first_err_addr_o(first_err_addr_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;

  // fault_mode: 0 ideal, 1 stuck-at-0 on bit fbit at addresses fa0/fa1, 2 every read inverted
  int fault_mode = 0, fa0 = 0, fa1 = 0, fbit = 0;
  logic [W-1:0] mem [E];

  function automatic logic [W-1:0] faulted(input logic [W-1:0] d, input int a);
    if (fault_mode == 1 && (a == fa0 || a == fa1)) return d & ~(W'(1) << fbit);
    if (fault_mode == 2) return ~d;
    return d;
  endfunction

  always @(posedge clk) begin
    if (w_v_o) mem[w_addr_o] <= w_data_o;
    if (r_v_o) r_data_i <= faulted(mem[r_addr_o], int'(r_addr_o));
  end

  function automatic logic [W-1:0] exp_word(input int pat, input int a, input int inv);
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) begin
      case (pat)
        0:       w[i] = 1'b0;
        1:       w[i] = 1'b1;
        2:       w[i] = (((i % 2) + (a % 2)) % 2) != 0;
        default: w[i] = ((a >> (i % AW)) % 2) != 0;
      endcase
    end
    return (inv != 0) ? ~w : w;
  endfunction

  task automatic model(input int pat, output int errs, output int first);
    bit found = 0;
    errs = 0; first = 0;
    for (int p = 0; p < PASSES; p++)
      for (int a = 0; a < E; a++) begin
        logic [W-1:0] e;
        e = exp_word(pat, a, p);
        if (faulted(e, a) !== e) begin
          if (!found) first = a;
          found = 1;
          errs++;
        end
      end
    errs = errs % (1 << CW);
  endtask

  int obs_lat, obs_wr_bad, obs_rd_bad, obs_wr_n, obs_rd_n, obs_overlap, obs_busy_bad;
  bit obs_clear_bad, obs_drop_bad, obs_prev_done;

  task automatic run_bist(input logic [1:0] pat, input bit toggle);
    int cyc = 0, wk = 0, rk = 0;
    bit seen = 0;
    obs_wr_bad = 0; obs_rd_bad = 0; obs_overlap = 0; obs_busy_bad = 0;
    obs_clear_bad = 0; obs_drop_bad = 0;
    @(negedge clk);
    obs_prev_done = done_o;
    start_i = 1; pattern_sel_i = pat;
    #1 if (done_o !== 1'b0) obs_drop_bad = 1;
    while (!seen && cyc < LAT + 20) begin
      @(negedge clk); cyc++;
      if (w_v_o && r_v_o) obs_overlap++;
      if (w_v_o) begin
        if (int'(w_addr_o) != wk % E || w_data_o !== exp_word(pat, wk % E, wk / E)) obs_wr_bad++;
        wk++;
      end
      if (r_v_o) begin
        if (int'(r_addr_o) != rk % E) obs_rd_bad++;
        rk++;
      end
      if (cyc == 1 && (err_count_o !== '0 || first_err_addr_o !== '0)) obs_clear_bad = 1;
      if (done_o === 1'b1) seen = 1;
      else if (busy_o !== 1'b1) obs_busy_bad++;
      pattern_sel_i = 2'($urandom);
      start_i = (toggle && cyc <= LAT - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    if (seen && busy_o !== 1'b0) obs_busy_bad++;
    obs_lat = seen ? cyc : -1;
    obs_wr_n = wk; obs_rd_n = rk;
  endtask

  task automatic test_reset();
    reset_i = 1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({w_v_o, r_v_o, busy_o, done_o, pass_o, err_count_o, first_err_addr_o, w_addr_o, r_addr_o, w_data_o} !== '0)
      $display("FAIL reset_outputs: got %h required 0", {w_v_o, r_v_o, busy_o, done_o, pass_o, err_count_o, first_err_addr_o});
    else n_pass++;
    reset_i = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy_o, done_o, w_v_o, r_v_o} !== 4'b0) $display("FAIL idle_after_reset: got %b required 0000", {busy_o, done_o, w_v_o, r_v_o});
    else n_pass++;
  endtask

  task automatic test_pattern2_ideal();
    int me, mf;
    fault_mode = 0;
    model(2, me, mf);
    run_bist(2'd2, 1'b0);
    n_checks++; if (obs_lat != LAT) $display("FAIL p2_latency: got %0d required %0d", obs_lat, LAT); else n_pass++;
    n_checks++; if (obs_wr_bad != 0 || obs_wr_n != PASSES*E) $display("FAIL p2_writes: bad %0d count %0d required 0 and %0d", obs_wr_bad, obs_wr_n, PASSES*E); else n_pass++;
    n_checks++; if (obs_rd_bad != 0 || obs_rd_n != PASSES*E) $display("FAIL p2_reads: bad %0d count %0d required 0 and %0d", obs_rd_bad, obs_rd_n, PASSES*E); else n_pass++;
    n_checks++; if (obs_overlap != 0) $display("FAIL p2_wr_rd_overlap: got %0d required 0", obs_overlap); else n_pass++;
    n_checks++; if (obs_busy_bad != 0) $display("FAIL p2_busy: got %0d bad cycles required 0", obs_busy_bad); else n_pass++;
    n_checks++; if (int'(err_count_o) != me || int'(first_err_addr_o) != mf || pass_o !== (me == 0))
      $display("FAIL p2_result: got err %0d first %0d pass %b required %0d %0d %b", err_count_o, first_err_addr_o, pass_o, me, mf, me == 0);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++; if (done_o !== 1'b1 || int'(err_count_o) != me || pass_o !== 1'b1)
      $display("FAIL p2_hold: got done %b err %0d pass %b required 1 %0d 1", done_o, err_count_o, pass_o, me);
    else n_pass++;
  endtask

  task automatic test_stuck_bits(input int bit_idx);
    int me, mf;
    fault_mode = 1; fa0 = 10; fa1 = 40; fbit = bit_idx;
    model(3, me, mf);
    run_bist(2'd3, 1'b0);
    n_checks++; if (obs_lat != LAT) $display("FAIL stuck%0d_latency: got %0d required %0d", bit_idx, obs_lat, LAT); else n_pass++;
    n_checks++; if (int'(err_count_o) != me || int'(first_err_addr_o) != mf || pass_o !== (me == 0))
      $display("FAIL stuck%0d_result: got err %0d first %0d pass %b required %0d %0d %b", bit_idx, err_count_o, first_err_addr_o, pass_o, me, mf, me == 0);
    else n_pass++;
  endtask

  task automatic test_corrupt_all();
    int me, mf;
    fault_mode = 2;
    model(1, me, mf);
    run_bist(2'd1, 1'b0);
    n_checks++; if (int'(err_count_o) != me || int'(first_err_addr_o) != mf || pass_o !== 1'b0)
      $display("FAIL corrupt_result: got err %0d first %0d pass %b required %0d %0d 0", err_count_o, first_err_addr_o, pass_o, me, mf);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    fault_mode = 0;
    run_bist(2'd0, 1'b0);
    n_checks++; if (obs_prev_done !== 1'b1 || obs_drop_bad) $display("FAIL b2b_done_drop: prev done %b drop_bad %b required 1 0", obs_prev_done, obs_drop_bad); else n_pass++;
    n_checks++; if (obs_clear_bad) $display("FAIL b2b_results_cleared: got stale results required cleared"); else n_pass++;
    n_checks++; if (obs_lat != LAT || pass_o !== 1'b1 || err_count_o !== '0)
      $display("FAIL b2b_result: got lat %0d pass %b err %0d required %0d 1 0", obs_lat, pass_o, err_count_o, LAT);
    else n_pass++;
  endtask

  task automatic test_start_toggle();
    logic [1:0] pat;
    fault_mode = 0;
    pat = 2'($urandom);
    run_bist(pat, 1'b1);
    n_checks++; if (obs_lat != LAT) $display("FAIL toggle_latency: got %0d required %0d", obs_lat, LAT); else n_pass++;
    n_checks++; if (obs_wr_bad != 0 || obs_rd_bad != 0 || pass_o !== 1'b1)
      $display("FAIL toggle_sequence: wr_bad %0d rd_bad %0d pass %b required 0 0 1", obs_wr_bad, obs_rd_bad, pass_o);
    else n_pass++;
  endtask

  task automatic test_mid_run_reset();
    fault_mode = 0;
    @(negedge clk); start_i = 1; pattern_sel_i = 2'd2;
    for (int c = 1; c <= 70; c++) begin @(negedge clk); start_i = 0; end
    n_checks++; if (r_v_o !== 1'b1) $display("FAIL midrun_in_read: got r_v %b required 1", r_v_o); else n_pass++;
    reset_i = 1;
    @(negedge clk);
    n_checks++;
    if ({w_v_o, r_v_o, busy_o, done_o, pass_o, err_count_o, first_err_addr_o, w_addr_o, r_addr_o, w_data_o} !== '0)
      $display("FAIL midrun_reset_outputs: got %h required 0", {w_v_o, r_v_o, busy_o, done_o, pass_o, err_count_o, first_err_addr_o});
    else n_pass++;
    reset_i = 0;
    repeat (3) @(negedge clk);
    n_checks++; if ({busy_o, done_o} !== 2'b00) $display("FAIL midrun_idle: got %b required 00", {busy_o, done_o}); else n_pass++;
    run_bist(2'd2, 1'b0);
    n_checks++; if (obs_lat != LAT || pass_o !== 1'b1)
      $display("FAIL midrun_fresh_run: got lat %0d pass %b required %0d 1", obs_lat, pass_o, LAT);
    else n_pass++;
  endtask

  task automatic test_invert_stuck();
    int me, mf;
    fault_mode = 1; fa0 = 7; fa1 = 7; fbit = $urandom_range(0, W-1);
    model(0, me, mf);
    run_bist(2'd0, 1'b0);
    n_checks++; if (obs_lat != LAT || obs_wr_bad != 0) $display("FAIL inv_latency_writes: got lat %0d wr_bad %0d required %0d 0", obs_lat, obs_wr_bad, LAT); else n_pass++;
    n_checks++; if (int'(err_count_o) != me || int'(first_err_addr_o) != mf || pass_o !== (me == 0))
      $display("FAIL inv_result: got err %0d first %0d pass %b required %0d %0d %b", err_count_o, first_err_addr_o, pass_o, me, mf, me == 0);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      int me, mf, pat;
      pat = $urandom_range(0, 3);
      fault_mode = $urandom_range(0, 1);
      fa0 = $urandom_range(0, E-1); fa1 = $urandom_range(0, E-1); fbit = $urandom_range(0, W-1);
      model(pat, me, mf);
      run_bist(2'(pat), 1'b0);
      n_checks++; if (obs_lat != LAT || obs_wr_bad != 0 || obs_rd_bad != 0)
        $display("FAIL rand%0d_sequence: lat %0d wr_bad %0d rd_bad %0d required %0d 0 0", k, obs_lat, obs_wr_bad, obs_rd_bad, LAT);
      else n_pass++;
      n_checks++; if (int'(err_count_o) != me || int'(first_err_addr_o) != mf || pass_o !== (me == 0))
        $display("FAIL rand%0d_result: got err %0d first %0d pass %b required %0d %0d %b", k, err_count_o, first_err_addr_o, pass_o, me, mf, me == 0);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_pattern2_ideal();
    test_stuck_bits(5);
    test_stuck_bits(3);
    test_corrupt_all();
    test_back_to_back();
    test_start_toggle();
    test_mid_run_reset();
    test_invert_stuck();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
